fifo_share_ctrl: RTL

- Sharing and sequencing controller in front of the 8-bit synchronous FIFO.
- Round-robin arbitrates two producers onto the FIFO write port and converts consumer read requests into legal FIFO reads.
- Keeps its own shadow occupancy counter so it never issues a write when the FIFO is full, or a read when it is empty, including the simultaneous read+write on empty case.
- Cross-checks the shadow count against the FIFO's empty/full flags and raises a sticky error on mismatch.

---
 rtl/fifo_share_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_share_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_share_ctrl
//   Sharing and sequencing controller placed in front of a synchronous FIFO.
//   Two producers are round-robin arbitrated onto the FIFO write port, and
//   consumer read requests are turned into legal FIFO reads. A shadow
//   occupancy counter keeps writes off a full FIFO and reads off an empty
//   one. The shadow count is cross-checked against the FIFO flags, and any
//   mismatch sets a sticky error.
//
// Ports
//   clk           in   rising-edge clock
//   clear         in   asynchronous active-high reset (also resets the FIFO)
//   req0 / data0  in   producer 0 request, held with its data until gnt0
//   req1 / data1  in   producer 1 request, held with its data until gnt1
//   gnt0 / gnt1   out  combinational same-cycle accept, at most one high
//   rd_req        in   consumer read request, one word per asserted cycle
//   rd_ack        out  combinational same-cycle accept of rd_req
//   fifo_wr       out  registered FIFO write strobe
//   fifo_data_in  out  registered FIFO write data
//   fifo_rd       out  registered FIFO read strobe
//   fifo_empty    in   FIFO empty flag
//   fifo_full     in   FIFO full flag
//   level         out  shadow occupancy (words committed to the FIFO)
//   err           out  sticky shadow-count / FIFO-flag mismatch
// ---------------------------------------------------------------------------
module fifo_share_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LW    = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             req0,
   input  logic [WIDTH-1:0] data0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   input  logic             rd_req,
   output logic             rd_ack,
   output logic             fifo_wr,
   output logic [WIDTH-1:0] fifo_data_in,
   output logic             fifo_rd,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   output logic [LW-1:0]    level,
   output logic             err
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic          wr_ok;
   logic          rd_ok;
   logic          favour1;   // 1: producer 1 wins the next contested cycle
   logic [LW-1:0] level_d;   // level delayed to line up with the FIFO flags
   logic          chk_en;    // flag check is armed from the second edge on

   // Credits come from the registered level only. A read issued in the same
   // cycle does not free a slot for a write, and a write issued in the same
   // cycle does not make a word available for a read.
   assign wr_ok = (level < DEPTH_L);
   assign rd_ok = (level != '0);

   // NOTE: every output of a combinational block is given a default first,
   //       so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (wr_ok) begin
         if (req0 && req1) begin
            gnt0 = !favour1;
            gnt1 = favour1;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign rd_ack = rd_req & rd_ok;

   // NOTE: state is updated with non-blocking assignments so that every
   //       register samples the pre-edge values, whatever order the
   //       statements appear in.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         fifo_wr      <= 1'b0;
         fifo_rd      <= 1'b0;
         fifo_data_in <= '0;
         favour1      <= 1'b0;
         level        <= '0;
         level_d      <= '0;
         chk_en       <= 1'b0;
         err          <= 1'b0;
      end else begin
         fifo_wr <= gnt0 | gnt1;
         fifo_rd <= rd_ack;

         // Write data holds its last value when nothing is granted.
         if (gnt0) begin
            fifo_data_in <= data0;
            favour1      <= 1'b1;
         end else if (gnt1) begin
            fifo_data_in <= data1;
            favour1      <= 1'b0;
         end

         // wr_ok and rd_ok already prevent overflow and underflow, so the
         // counter needs no extra clamping.
         case ({gnt0 | gnt1, rd_ack})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         // A command seen at edge N reaches the FIFO at edge N+1, so the
         // flags reflect the level one edge later. The first edge after
         // reset only arms the check.
         level_d <= level;
         chk_en  <= 1'b1;
         if (chk_en &&
             ((fifo_empty != (level_d == '0)) ||
              (fifo_full  != (level_d == DEPTH_L))))
            err <= 1'b1;
      end
   end

endmodule
